// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and default word width for the PISO shifter
package piso_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: bit index within the current word, saturating at WIDTH-1
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);
    localparam int CW = $clog2(WIDTH);

    assign tc = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !tc)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in serial-out shifter with valid/ready load and en bit strobe
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;
    logic             tc, busy, step, last, accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = accept ? SHIFT : (last ? IDLE : state);
    end

    always_comb begin
        busy       = state == SHIFT;
        step       = busy && en;
        last       = step && tc;
        in_ready   = !busy || last;
        done       = last;
        accept     = in_valid && in_ready;
        sout_valid = busy;
        sout       = busy && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
    end

    // Shift toward the output end, zero-filling; the last bit is replaced by a reload or dropped on IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shift_reg <= '0;
        else if (accept)
            shift_reg <= in_data;
        else if (step && !tc)
            shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
    end

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .inc     (step && !tc),
        .cnt     (cnt),
        .tc      (tc)
    );
endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: vector table, directed corner sequences and random stimulus against a bit-queue model
module tb_piso_shifter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         en;
    logic         rdy_m, sout_m, sv_m, done_m;
    logic         rdy_l, sout_l, sv_l, done_l;

    int total = 0;
    int bad = 0;
    int dones, ens, done_at, sv_cnt, run, maxrun;

    logic qm[$];
    logic ql[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         e;
        logic         rdy;
        logic         so_m;
        logic         so_l;
        logic         sv;
        logic         dn;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_m),
        .en(en), .sout(sout_m), .sout_valid(sv_m), .done(done_m)
    );

    piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_l),
        .en(en), .sout(sout_l), .sout_valid(sv_l), .done(done_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [W-1:0] d, input logic e);
        in_valid = v;
        in_data  = d;
        en       = e;
        #1;
    endtask

    // Model: pending bits of the current word in transmit order; in_ready when the queue drains this cycle
    task automatic tick();
        logic r, dn, bm, bl;
        r  = (qm.size() == 0) || (qm.size() == 1 && en);
        dn = (qm.size() == 1) && en;
        bm = (qm.size() > 0) ? qm[0] : 1'b0;
        bl = (ql.size() > 0) ? ql[0] : 1'b0;
        check("m_ready", rdy_m, r);
        check("m_sout", sout_m, bm);
        check("m_valid", sv_m, qm.size() > 0);
        check("m_done", done_m, dn);
        check("l_ready", rdy_l, r);
        check("l_sout", sout_l, bl);
        check("l_valid", sv_l, ql.size() > 0);
        check("l_done", done_l, dn);
        if (sv_m && en) ens++;
        if (done_m) begin
            dones++;
            done_at = ens;
        end
        sv_cnt += int'(sv_m);
        run = sv_m ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
        @(posedge clk);
        if (en && qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (in_valid && r)
            for (int i = 0; i < W; i++) begin
                qm.push_back(in_data[W-1-i]);
                ql.push_back(in_data[i]);
            end
        #1;
    endtask

    task automatic clr_stats();
        dones = 0; ens = 0; done_at = -1; sv_cnt = 0; run = 0; maxrun = 0;
    endtask

    initial begin
        logic [W-1:0] w;
        w = 8'hA5;
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 8'h00, 1'b1, i == 8, w[8-i], w[i-1], 1'b1, i == 8};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        clr_stats();

        reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; en = 1'b0;
        #12;
        check("rst_sout_m", sout_m, 1'b0);
        check("rst_valid_m", sv_m, 1'b0);
        check("rst_done_m", done_m, 1'b0);
        check("rst_sout_l", sout_l, 1'b0);
        check("rst_valid_l", sv_l, 1'b0);
        check("rst_done_l", done_l, 1'b0);
        reset_n = 1'b1;

        // 0xA5 accepted at the first edge after release, en held high
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; en = tbl[i].e;
            #1;
            check($sformatf("tbl%0d_ready", i), rdy_m, tbl[i].rdy);
            check($sformatf("tbl%0d_sout_m", i), sout_m, tbl[i].so_m);
            check($sformatf("tbl%0d_sout_l", i), sout_l, tbl[i].so_l);
            check($sformatf("tbl%0d_valid", i), sv_m, tbl[i].sv);
            check($sformatf("tbl%0d_done", i), done_m, tbl[i].dn);
            tick();
        end

        // 0xC3 with en every 3rd cycle
        clr_stats();
        drv(1'b1, 8'hC3, 1'b0); tick();
        for (int c = 0; c < 27; c++) begin
            drv(1'b0, 8'h00, c % 3 == 2); tick();
        end
        check_int("slow_dones", dones, 1);
        check_int("slow_done_at_en", done_at, 8);
        check_int("slow_valid_cycles", sv_cnt, 24);

        // 0x81 then 0x7E back to back
        clr_stats();
        drv(1'b1, 8'h81, 1'b1); tick();
        for (int c = 0; c < 8; c++) begin
            drv(1'b1, 8'h7E, 1'b1); tick();
        end
        for (int c = 0; c < 9; c++) begin
            drv(1'b0, 8'h00, 1'b1); tick();
        end
        check_int("b2b_dones", dones, 2);
        check_int("b2b_valid_cycles", sv_cnt, 16);
        check_int("b2b_contig", maxrun, 16);

        // asynchronous reset mid-word of 0xFF
        clr_stats();
        drv(1'b1, 8'hFF, 1'b1); tick();
        for (int c = 0; c < 4; c++) begin
            drv(1'b0, 8'h00, 1'b1); tick();
        end
        #2 reset_n = 1'b0;
        #1;
        check("arst_sout", sout_m, 1'b0);
        check("arst_valid", sv_m, 1'b0);
        check("arst_done", done_m, 1'b0);
        check("arst_sout_l", sout_l, 1'b0);
        qm.delete();
        ql.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("arst_ready_after", rdy_m, 1'b1);
        drv(1'b0, 8'h00, 1'b1); tick();
        check_int("arst_no_done", dones, 0);

        // busy with in_valid high, en toggling, in_data churning
        drv(1'b1, 8'h3C, 1'b0); tick();
        for (int c = 0; c < 30; c++) begin
            drv(1'b1, 8'($urandom), c[0]); tick();
        end

        for (int c = 0; c < 400; c++) begin
            drv(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1))); tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
